// File: rtl/sram_access_ctrl.sv
// Request-side sequencer for the SRAM array: splits word-unit addresses into
// row/lane fields for the bitline-mask decoder, sequences wordline and sense
// timing, replicates write data across lanes and extracts read data.
module sram_access_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int ROW_W     = 8,
    parameter int WL_CYC    = 2,
    parameter int SENSE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_conf,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ROW_W-1:0]  row_addr,
    output logic [1:0]        lane_addr,
    output logic [1:0]        conf_out,
    output logic              wl_en,
    output logic              we,
    output logic              sense_en,
    output logic [31:0]       wdata_bl,
    input  logic [31:0]       array_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] WL_LAST    = CNT_W'(WL_CYC - 1);
    localparam logic [CNT_W-1:0] SENSE_LAST = CNT_W'(SENSE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WL    = 2'd1,
        ST_SENSE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_we_q, req_we_d;

    logic               wl_en_q, we_str_q, sense_en_q, resp_valid_q, req_ready_q;
    logic [ROW_W-1:0]   row_q;
    logic [1:0]         lane_q;
    logic [1:0]         conf_q;
    logic [31:0]        wdata_bl_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_err_q;

    logic               accept_s;
    logic               sense_done_s;
    logic               resp_done_s;
    logic               dec_err_s;
    logic [ROW_W-1:0]   dec_row_s;
    logic [1:0]         dec_lane_s;
    logic [31:0]        dec_wdata_s;

    // Replicate LSB-aligned narrow write data across every lane it may land in.
    function automatic logic [31:0] replicate_wdata(input logic [1:0] conf, input logic [31:0] data);
        logic [31:0] res;
        case (conf)
            2'b00:   res = data;
            2'b01:   res = {2{data[15:0]}};
            2'b10:   res = {4{data[7:0]}};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Pick the addressed half/byte out of the raw row word and zero-extend it.
    function automatic logic [31:0] extract_rdata(input logic [1:0] conf, input logic [1:0] lane,
                                                  input logic [31:0] data);
        logic [31:0] res;
        case (conf)
            2'b00: res = data;
            2'b01: begin
                if (lane[0]) begin
                    res = {16'd0, data[31:16]};
                end else begin
                    res = {16'd0, data[15:0]};
                end
            end
            2'b10: begin
                case (lane)
                    2'd0:    res = {24'd0, data[7:0]};
                    2'd1:    res = {24'd0, data[15:8]};
                    2'd2:    res = {24'd0, data[23:16]};
                    2'd3:    res = {24'd0, data[31:24]};
                    default: res = 32'd0;
                endcase
            end
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    assign accept_s     = (state_q == ST_IDLE) && req_valid;
    assign sense_done_s = (state_q == ST_SENSE) && (cnt_q == SENSE_LAST);
    assign resp_done_s  = (state_q == ST_RESP) && resp_ready;

    // Address split and range check for the incoming request.
    always_comb begin
        dec_err_s   = 1'b0;
        dec_row_s   = '0;
        dec_lane_s  = 2'd0;
        case (req_conf)
            2'b00: begin
                dec_row_s  = req_addr[ROW_W-1:0];
                dec_lane_s = 2'd0;
                dec_err_s  = |req_addr[ADDR_W-1:ROW_W];
            end
            2'b01: begin
                dec_row_s  = req_addr[ROW_W:1];
                dec_lane_s = {1'b0, req_addr[0]};
                dec_err_s  = req_addr[ADDR_W-1];
            end
            2'b10: begin
                dec_row_s  = req_addr[ADDR_W-1:2];
                dec_lane_s = req_addr[1:0];
                dec_err_s  = 1'b0;
            end
            default: begin
                dec_err_s  = 1'b1;
            end
        endcase
        dec_wdata_s = dec_err_s ? 32'd0 : replicate_wdata(req_conf, req_wdata);
    end

    // Next-state, phase counter and latched-direction logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_we_d = req_we_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d    = '0;
                    req_we_d = req_we;
                    state_d  = dec_err_s ? ST_RESP : ST_WL;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WL: begin
                if (cnt_q == WL_LAST) begin
                    cnt_d   = '0;
                    state_d = req_we_q ? ST_RESP : ST_SENSE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_SENSE: begin
                if (cnt_q == SENSE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and strobe registers; strobes are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_we_q     <= 1'b0;
            wl_en_q      <= 1'b0;
            we_str_q     <= 1'b0;
            sense_en_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_we_q     <= req_we_d;
            wl_en_q      <= (state_d == ST_WL);
            we_str_q     <= (state_d == ST_WL) && req_we_d;
            sense_en_q   <= (state_d == ST_SENSE);
            resp_valid_q <= (state_d == ST_RESP);
            req_ready_q  <= (state_d == ST_IDLE);
        end
    end

    // Request fields latched at accept, read data captured on the last sense cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= '0;
            lane_q       <= 2'd0;
            conf_q       <= 2'd0;
            wdata_bl_q   <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                wdata_bl_q   <= dec_wdata_s;
                resp_err_q   <= dec_err_s;
                resp_rdata_q <= 32'd0;
                if (!dec_err_s) begin
                    row_q  <= dec_row_s;
                    lane_q <= dec_lane_s;
                    conf_q <= req_conf;
                end
            end else if (sense_done_s) begin
                resp_rdata_q <= extract_rdata(conf_q, lane_q, array_rdata);
            end else if (resp_done_s) begin
                resp_err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign row_addr   = row_q;
    assign lane_addr  = lane_q;
    assign conf_out   = conf_q;
    assign wl_en      = wl_en_q;
    assign we         = we_str_q;
    assign sense_en   = sense_en_q;
    assign wdata_bl   = wdata_bl_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Request-side sequencer directly upstream of the SRAM bitline-mask decoder. It accepts word-unit read/write requests in 32-, 16- or 8-bit configuration, splits the address into row and lane fields, and drives lane_addr/conf straight into the mask decoder. It also sequences wordline/sense timing, replicates write data across byte lanes and extracts/zero-extends read data.

Parameters:
ADDR_W, 10, request address width in units of the configured word size
ROW_W, 8, array row address width; must equal ADDR_W-2
WL_CYC, 2, cycles wl_en is held per access (>=1)
SENSE_CYC, 1, cycles sense_en is held on reads (>=1)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_conf  in  2  00 = 32-bit, 01 = 16-bit, 10 = 8-bit, 11 = reserved
req_addr  in  ADDR_W  word-unit address
req_wdata  in  32  write data, LSB-aligned narrow data
row_addr  out  ROW_W  array row select
lane_addr  out  2  to mask decoder addr
conf_out  out  2  to mask decoder conf
wl_en  out  1  wordline enable
we  out  1  array write enable, qualified with wl_en
sense_en  out  1  sense-amp enable
wdata_bl  out  32  lane-replicated write data to bitline drivers
array_rdata  in  32  raw row data from sense amps
resp_valid  out  1  response valid
resp_ready  in  1  response accepted
resp_rdata  out  32  zero-extended read data; 0 for writes and errors
resp_err  out  1  request rejected, no array access

Behaviour:
- Reset, asynchronous: state IDLE; req_ready=1; wl_en, we, sense_en, resp_valid and resp_err = 0; row_addr, lane_addr, conf_out, wdata_bl and resp_rdata = 0. All array strobes drop immediately, including mid-access.
- States: IDLE, WL, SENSE, RESP. req_ready=1 only in IDLE. A request is accepted on the edge where req_valid&&req_ready.
- Accept: register req_we, conf, row_addr, lane_addr and wdata_bl. The address split and error check are combinational on req_* and registered at accept.
  - conf 00: row=addr[ROW_W-1:0], lane=00; error if addr[ADDR_W-1:ROW_W]!=0.
  - conf 01: row=addr[ROW_W:1], lane={0,addr[0]}; error if addr[ADDR_W-1]!=0.
  - conf 10: row=addr[ADDR_W-1:2], lane=addr[1:0]; no range error.
  - conf 11: always an error.
- Write data replication:
  - conf 00: wdata_bl=req_wdata.
  - conf 01: wdata_bl={2{req_wdata[15:0]}}.
  - conf 10: wdata_bl={4{req_wdata[7:0]}}.
  - Error: wdata_bl=0.
- On error: go IDLE->RESP with resp_err=1 and resp_rdata=0. wl_en, we and sense_en never assert, and row/lane/conf_out keep their previous values.
- WL state: wl_en=1, and we=req_we, for exactly WL_CYC cycles (internal counter).
  - Write: WL->RESP.
  - Read: WL->SENSE.
- SENSE state: sense_en=1 for SENSE_CYC cycles; wl_en=0. array_rdata is sampled on the last SENSE edge.
- Read extraction, consistent with the active-low lane mask (lane 0 = bits 7:0, half 1 = bits 31:16):
  - conf 00: resp_rdata = full word.
  - conf 01: resp_rdata = {16'b0, half[lane_addr[0]]}.
  - conf 10: resp_rdata = {24'b0, byte[lane_addr]}.
- RESP state: resp_valid=1, with resp_rdata and resp_err stable, until resp_valid&&resp_ready. On that edge go to IDLE and clear resp_valid/resp_err. req_ready returns the following cycle; no same-cycle back-to-back accept.
- row_addr/lane_addr/conf_out stay stable from accept through RESP and hold afterwards until the next non-error accept.
- Latency with defaults (accept edge = cycle 0):
  - Read: wl_en in cycles 1-2, sense_en in cycle 3, resp_valid from cycle 4.
  - Write: wl_en/we in cycles 1-2, resp_valid from cycle 3.
  - Error: resp_valid from cycle 1.
- req_* inputs are ignored outside IDLE. resp_ready is ignored outside RESP.

Test Plan:
- Reset, then idle: req_ready=1 and all strobes 0. Assert rst mid-WL -> wl_en falls asynchronously; after release, state is IDLE with req_ready=1.
- Write, conf=10, addr=0x2D7, wdata=0x000000A5 -> row_addr=0xB5, lane_addr=3, conf_out=10, wdata_bl=0xA5A5A5A5. we/wl_en high in cycles 1-2; resp_valid in cycle 3 with resp_err=0.
- Read, conf=01, addr=0x0C3, array_rdata=0xDEADBEEF -> row_addr=0x61, lane_addr=01, sense_en in cycle 3. resp_valid in cycle 4 with resp_rdata=0x0000DEAD.
- Read, conf=10, addr=0x000 and then addr=0x003, array_rdata=0xDEADBEEF -> resp_rdata 0x000000EF and 0x000000DE respectively.
- Error cases: conf=00 addr=0x100, and conf=11 addr=0x000 -> resp_err=1 and resp_rdata=0 in cycle 1; wl_en/sense_en never assert.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable and req_ready=0. When resp_ready=1, handshake completes and req_ready=1 on the next cycle.
